// File: rtl/axi_lite_mem_responder_if.sv
// Five-channel read/write bus between the sorter (master) and the memory
// responder (slave). Handshakes: a beat transfers on a rising edge where both valid and ready are high.
interface axi_lite_mem_responder_if #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
) ();
    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_WDTH-1:0] ar_address;
    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_WDTH-1:0] r_data;
    logic [RESP_WDTH-1:0] r_resp;
    logic                 aw_valid;
    logic                 aw_ready;
    logic [ADDR_WDTH-1:0] aw_address;
    logic                 w_valid;
    logic                 w_ready;
    logic [DATA_WDTH-1:0] w_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [RESP_WDTH-1:0] b_resp;

    modport master (
        output ar_valid, ar_address, r_ready,
        output aw_valid, aw_address, w_valid, w_data, b_ready,
        input  ar_ready, r_valid, r_data, r_resp,
        input  aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  ar_valid, ar_address, r_ready,
        input  aw_valid, aw_address, w_valid, w_data, b_ready,
        output ar_ready, r_valid, r_data, r_resp,
        output aw_ready, w_ready, b_valid, b_resp
    );
endinterface

// File: rtl/axi_lite_mem_responder.sv
// Memory-backed bus responder with programmable wait states and forced or
// address-targeted error responses. Independent read and write FSMs share one word array.
module axi_lite_mem_responder #(
    parameter int                   ADDR_WDTH = 4,
    parameter int                   DATA_WDTH = 32,
    parameter int                   RESP_WDTH = 1,
    parameter int                   LAT_WDTH  = 4,
    parameter logic [ADDR_WDTH-1:0] ERR_ADDR  = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                always_success,
    input  logic                always_error,
    input  logic [LAT_WDTH-1:0] rd_lat,
    input  logic [LAT_WDTH-1:0] wr_lat,
    axi_lite_mem_responder_if.slave bus,
    output logic                switch_case_default,
    output logic [1:0]          rd_state_o,
    output logic [1:0]          wr_state_o
);
    localparam int DEPTH = 2 ** ADDR_WDTH;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_WAIT = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

    logic [DATA_WDTH-1:0] mem_q [DEPTH];

    rd_state_e            rd_state_q;
    logic [ADDR_WDTH-1:0] rd_addr_q;
    logic                 rd_err_q;
    logic [LAT_WDTH-1:0]  rd_cnt_q;
    logic                 ar_ready_q;
    logic                 r_valid_q;
    logic [DATA_WDTH-1:0] r_data_q;
    logic [RESP_WDTH-1:0] r_resp_q;
    logic                 rd_bad_q;

    wr_state_e            wr_state_q;
    logic [ADDR_WDTH-1:0] wr_addr_q;
    logic                 wr_err_q;
    logic [LAT_WDTH-1:0]  wr_cnt_q;
    logic [DATA_WDTH-1:0] wr_data_q;
    logic                 aw_ready_q;
    logic                 w_ready_q;
    logic                 b_valid_q;
    logic [RESP_WDTH-1:0] b_resp_q;
    logic                 wr_bad_q;

    // Error decision for the address being presented; sampled only at capture.
    logic rd_err_d;
    logic wr_err_d;
    always_comb begin
        rd_err_d = always_error | (~always_success & (bus.ar_address == ERR_ADDR));
        wr_err_d = always_error | (~always_success & (bus.aw_address == ERR_ADDR));
    end

    // Read FSM. r_valid follows entry into R_RESP by one edge, which gives
    // the AR-to-R latency of 1 + rd_lat cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_err_q   <= 1'b0;
            rd_cnt_q   <= '0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
            rd_bad_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (bus.ar_valid) begin
                        rd_addr_q  <= bus.ar_address;
                        rd_err_q   <= rd_err_d;
                        rd_cnt_q   <= rd_lat;
                        ar_ready_q <= 1'b0;
                        if (rd_lat != '0) begin
                            rd_state_q <= R_WAIT;
                        end else begin
                            rd_state_q <= R_RESP;
                            r_data_q   <= rd_err_d ? '0 : mem_q[bus.ar_address];
                            r_resp_q   <= RESP_WDTH'(rd_err_d);
                        end
                    end
                end
                R_WAIT: begin
                    rd_cnt_q <= rd_cnt_q - 1'b1;
                    if (rd_cnt_q == LAT_WDTH'(1)) begin
                        rd_state_q <= R_RESP;
                        r_data_q   <= rd_err_q ? '0 : mem_q[rd_addr_q];
                        r_resp_q   <= RESP_WDTH'(rd_err_q);
                    end
                end
                R_RESP: begin
                    if (r_valid_q && bus.r_ready) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end else begin
                        r_valid_q <= 1'b1;
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                    ar_ready_q <= 1'b1;
                    r_valid_q  <= 1'b0;
                    rd_bad_q   <= 1'b1;
                end
            endcase
        end
    end

    // Write FSM. The array is committed on entry to W_RESP and only for OKAY,
    // so a read entering R_RESP on the same edge still sees the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_err_q   <= 1'b0;
            wr_cnt_q   <= '0;
            wr_data_q  <= '0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= '0;
            wr_bad_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_WDTH'(DEPTH - 1 - i);
            end
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (bus.aw_valid) begin
                        wr_addr_q  <= bus.aw_address;
                        wr_err_q   <= wr_err_d;
                        aw_ready_q <= 1'b0;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_ready_q && bus.w_valid) begin
                        wr_data_q <= bus.w_data;
                        wr_cnt_q  <= wr_lat;
                        w_ready_q <= 1'b0;
                        if (wr_lat != '0) begin
                            wr_state_q <= W_WAIT;
                        end else begin
                            wr_state_q <= W_RESP;
                            b_resp_q   <= RESP_WDTH'(wr_err_q);
                            if (!wr_err_q) mem_q[wr_addr_q] <= bus.w_data;
                        end
                    end else begin
                        w_ready_q <= 1'b1;
                    end
                end
                W_WAIT: begin
                    wr_cnt_q <= wr_cnt_q - 1'b1;
                    if (wr_cnt_q == LAT_WDTH'(1)) begin
                        wr_state_q <= W_RESP;
                        b_resp_q   <= RESP_WDTH'(wr_err_q);
                        if (!wr_err_q) mem_q[wr_addr_q] <= wr_data_q;
                    end
                end
                W_RESP: begin
                    if (b_valid_q && bus.b_ready) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end else begin
                        b_valid_q <= 1'b1;
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                    aw_ready_q <= 1'b1;
                    w_ready_q  <= 1'b0;
                    b_valid_q  <= 1'b0;
                    wr_bad_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ar_ready = ar_ready_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = r_data_q;
    assign bus.r_resp   = r_resp_q;
    assign bus.aw_ready = aw_ready_q;
    assign bus.w_ready  = w_ready_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.b_resp   = b_resp_q;

    assign switch_case_default = rd_bad_q | wr_bad_q;
    assign rd_state_o          = rd_state_q;
    assign wr_state_o          = wr_state_q;
endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed bench for axi_lite_mem_responder: drivers push expected responses,
// and independent monitors pop and compare on every R and B handshake.
module tb_axi_lite_mem_responder;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int RW = 1;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          always_success = 1'b0;
    logic          always_error = 1'b0;
    logic [LW-1:0] rd_lat = '0;
    logic [LW-1:0] wr_lat = '0;
    logic          scd;
    logic [1:0]    rd_st;
    logic [1:0]    wr_st;

    axi_lite_mem_responder_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) bus ();

    axi_lite_mem_responder #(
        .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .LAT_WDTH(LW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .always_success      (always_success),
        .always_error        (always_error),
        .rd_lat              (rd_lat),
        .wr_lat              (wr_lat),
        .bus                 (bus),
        .switch_case_default (scd),
        .rd_state_o          (rd_st),
        .wr_state_o          (wr_st)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW:0]   rd_exp_q[$];
    logic [RW-1:0] b_exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rst && bus.r_valid && bus.r_ready) begin
            if (rd_exp_q.size() == 0) begin
                timeout_fail("r_unexpected");
            end else begin
                e = rd_exp_q.pop_front();
                check("r_data", 64'(bus.r_data), 64'(e[DW-1:0]));
                check("r_resp", 64'(bus.r_resp), 64'(e[DW]));
            end
        end
    end

    always @(negedge clk) begin
        logic [RW-1:0] e;
        if (!rst && bus.b_valid && bus.b_ready) begin
            if (b_exp_q.size() == 0) begin
                timeout_fail("b_unexpected");
            end else begin
                e = b_exp_q.pop_front();
                check("b_resp", 64'(bus.b_resp), 64'(e));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ar_ready"}, 64'(bus.ar_ready), 64'd1);
        check({tag, "_aw_ready"}, 64'(bus.aw_ready), 64'd1);
        check({tag, "_w_ready"},  64'(bus.w_ready),  64'd0);
        check({tag, "_r_valid"},  64'(bus.r_valid),  64'd0);
        check({tag, "_b_valid"},  64'(bus.b_valid),  64'd0);
        check({tag, "_r_data"},   64'(bus.r_data),   64'd0);
        check({tag, "_r_resp"},   64'(bus.r_resp),   64'd0);
        check({tag, "_b_resp"},   64'(bus.b_resp),   64'd0);
        check({tag, "_scd"},      64'(scd),          64'd0);
    endtask

    // Driver: read with optional r_ready back-pressure for `hold` cycles
    task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] lat,
                           input logic [DW-1:0] ed, input logic [RW-1:0] er, input int hold);
        int k;
        rd_exp_q.push_back({er, ed});
        bus.r_ready    = (hold == 0);
        bus.ar_address = a;
        rd_lat         = lat;
        bus.ar_valid   = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.ar_ready && k < 50);
        if (!bus.ar_ready) timeout_fail("ar_handshake");
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        check("ar_ready_busy", 64'(bus.ar_ready), 64'd0);
        k = 0;
        while (!bus.r_valid && k < 40) begin @(posedge clk); #1; k++; end
        check("rd_latency", 64'(k), 64'(1 + lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r_valid_hold", 64'(bus.r_valid), 64'd1);
            check("ar_ready_hold", 64'(bus.ar_ready), 64'd0);
            check("r_data_hold", 64'(bus.r_data), 64'(ed));
            check("r_resp_hold", 64'(bus.r_resp), 64'(er));
        end
        if (hold > 0) begin @(posedge clk); #1; bus.r_ready = 1'b1; end
        k = 0;
        do begin @(negedge clk); k++; end while (!(bus.r_valid && bus.r_ready) && k < 50);
        if (!(bus.r_valid && bus.r_ready)) timeout_fail("r_handshake");
        @(posedge clk); #1;
        check("r_valid_drop", 64'(bus.r_valid), 64'd0);
        check("ar_ready_back", 64'(bus.ar_ready), 64'd1);
    endtask

    // Driver: AW then W phases; returns #1 after the W handshake edge
    task automatic aw_w_phase(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LW-1:0] lat);
        int k;
        bus.b_ready    = 1'b1;
        bus.aw_address = a;
        bus.aw_valid   = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.aw_ready && k < 50);
        if (!bus.aw_ready) timeout_fail("aw_handshake");
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        bus.w_data   = d;
        wr_lat       = lat;
        bus.w_valid  = 1'b1;
        k = 0;
        while (!bus.w_ready && k < 20) begin @(posedge clk); #1; k++; end
        check("w_ready_latency", 64'(k), 64'd1);
        check("aw_ready_busy", 64'(bus.aw_ready), 64'd0);
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
        check("w_ready_drop", 64'(bus.w_ready), 64'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [LW-1:0] lat, input logic [RW-1:0] er);
        int k;
        b_exp_q.push_back(er);
        aw_w_phase(a, d, lat);
        k = 0;
        while (!bus.b_valid && k < 40) begin @(posedge clk); #1; k++; end
        check("wr_latency", 64'(k), 64'(1 + lat));
        k = 0;
        do begin @(negedge clk); k++; end while (!(bus.b_valid && bus.b_ready) && k < 50);
        if (!(bus.b_valid && bus.b_ready)) timeout_fail("b_handshake");
        @(posedge clk); #1;
        check("b_valid_drop", 64'(bus.b_valid), 64'd0);
        check("aw_ready_back", 64'(bus.aw_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ar_valid = 1'b0; bus.ar_address = '0; bus.r_ready = 1'b1;
        bus.aw_valid = 1'b0; bus.aw_address = '0; bus.w_valid = 1'b0;
        bus.w_data = '0; bus.b_ready = 1'b1;
        #2 rst = 1'b1;
        #2 check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Plain read of the descending reset image
        do_read(4'd3, 4'd0, 32'd12, 1'b0, 0);
        // Write with wait states, read back
        do_write(4'd5, 32'hDEADBEEF, 4'd3, 1'b0);
        do_read(4'd5, 4'd2, 32'hDEADBEEF, 1'b0, 0);
        // Forced error: write dropped, read data zeroed
        always_error = 1'b1;
        do_write(4'd2, 32'h1, 4'd0, 1'b1);
        do_read(4'd2, 4'd1, 32'd0, 1'b1, 0);
        always_error = 1'b0;
        do_read(4'd2, 4'd0, 32'd13, 1'b0, 0);
        // Targeted error at address 15, neighbour 14 is OKAY
        do_write(4'd15, 32'h55, 4'd0, 1'b1);
        do_read(4'd15, 4'd0, 32'd0, 1'b1, 0);
        do_write(4'd14, 32'hA5A5A5A5, 4'd1, 1'b0);
        do_read(4'd14, 4'd0, 32'hA5A5A5A5, 1'b0, 0);
        // always_success overrides the target; always_error overrides both
        always_success = 1'b1;
        do_write(4'd15, 32'h77, 4'd2, 1'b0);
        do_read(4'd15, 4'd0, 32'h77, 1'b0, 0);
        always_error = 1'b1;
        do_read(4'd14, 4'd0, 32'd0, 1'b1, 0);
        always_error = 1'b0;
        always_success = 1'b0;
        // Back-pressure on R
        do_read(4'd14, 4'd0, 32'hA5A5A5A5, 1'b0, 5);
        // Maximum latency, no wrap
        do_read(4'd7, 4'd15, 32'd8, 1'b0, 0);
        do_write(4'd9, 32'h0BADF00D, 4'd15, 1'b0);
        do_read(4'd9, 4'd0, 32'h0BADF00D, 1'b0, 0);

        // Reset during W_WAIT abandons the write
        aw_w_phase(4'd0, 32'h12345678, 4'd10);
        repeat (3) begin @(posedge clk); #1; end
        check("wwait_b_valid", 64'(bus.b_valid), 64'd0);
        rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        check("post_rst_b_valid", 64'(bus.b_valid), 64'd0);
        do_read(4'd0, 4'd0, 32'd15, 1'b0, 0);
        do_read(4'd5, 4'd0, 32'd10, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_empty", 64'(rd_exp_q.size()), 64'd0);
        check("b_queue_empty", 64'(b_exp_q.size()), 64'd0);
        check("scd_final", 64'(scd), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
